// File: rtl/cv32e40p_div_pkg.sv
// Shared types and constants for the divider arbiter and its operand-prep helper.
package cv32e40p_div_pkg;

  // Default watchdog limit. It must stay above the divider's worst-case latency.
  localparam int unsigned C_WDOG_CYC_DEF = 48;

  // Divider opcodes. The odd encodings are the signed variants.
  typedef enum logic [1:0] {
    DIV_UDIV = 2'd0,
    DIV_DIV  = 2'd1,
    DIV_UREM = 2'd2,
    DIV_REM  = 2'd3
  } div_opcode_e;

  // Arbiter / sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP,
    DRAIN
  } div_arb_state_e;

endpackage

// File: rtl/cv32e40p_div_prep.sv
// Combinational divisor side-band derivation: sign, zero flag and the
// leading-zero count of |OpB| that the serial divider uses as its start shift.
module cv32e40p_div_prep
  import cv32e40p_div_pkg::*;
#(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_WIDTH = 6
) (
  input  logic [C_WIDTH-1:0]     OpB_DI,
  input  div_opcode_e            OpCode_SI,
  output logic                   OpBSign_SO,
  output logic                   OpBIsZero_SO,
  output logic [C_LOG_WIDTH-1:0] OpBShift_SO
);

  logic               signed_op;
  logic [C_WIDTH-1:0] abs_b;

  assign signed_op    = (OpCode_SI == DIV_DIV) || (OpCode_SI == DIV_REM);
  assign OpBSign_SO   = signed_op & OpB_DI[C_WIDTH-1];
  assign OpBIsZero_SO = (OpB_DI == '0);
  assign abs_b        = OpBSign_SO ? (~OpB_DI + 1'b1) : OpB_DI;

  // Leading-zero count of |OpB|; the highest set bit wins, C_WIDTH when zero.
  always_comb begin
    // NOTE: default assigned before the loop so every path drives the output (no latch).
    OpBShift_SO = C_LOG_WIDTH'(C_WIDTH);
    for (int i = 0; i < int'(C_WIDTH); i++) begin
      if (abs_b[i]) OpBShift_SO = C_LOG_WIDTH'(int'(C_WIDTH) - 1 - i);
    end
  end

endmodule

// File: rtl/cv32e40p_div_arbiter.sv
// Two-way round-robin arbiter and handshake sequencer in front of the single
// serial divider. Operands and side-band values are registered at accept, the
// divider is started with a one-cycle InVld pulse, and the result is returned
// to the requester that owns the operation. Flush drains the divider silently;
// a watchdog aborts an operation whose result never arrives.
module cv32e40p_div_arbiter
  import cv32e40p_div_pkg::*;
#(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_WIDTH = 6,
  parameter int unsigned C_WDOG_CYC  = C_WDOG_CYC_DEF
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RI,
  input  logic [1:0]                  ReqVld_SI,
  output logic [1:0]                  ReqRdy_SO,
  input  logic [1:0][C_WIDTH-1:0]     ReqOpA_DI,
  input  logic [1:0][C_WIDTH-1:0]     ReqOpB_DI,
  input  logic [1:0][1:0]             ReqOpCode_SI,
  output logic [1:0]                  RspVld_SO,
  input  logic [1:0]                  RspRdy_SI,
  output logic [C_WIDTH-1:0]          RspRes_DO,
  output logic                        RspErr_SO,
  input  logic                        Flush_SI,
  output logic                        Busy_SO,
  output logic [C_WIDTH-1:0]          DivOpA_DO,
  output logic [C_WIDTH-1:0]          DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0]      DivOpBShift_DO,
  output logic                        DivOpBIsZero_SO,
  output logic                        DivOpBSign_SO,
  output logic [1:0]                  DivOpCode_SO,
  output logic                        DivInVld_SO,
  output logic                        DivOutRdy_SO,
  input  logic                        DivOutVld_SI,
  input  logic [C_WIDTH-1:0]          DivRes_DI
);

  localparam int unsigned C_WDOG_W = $clog2(C_WDOG_CYC + 1);

  div_arb_state_e         state_d, state_q;
  logic                   rr_d, rr_q;
  logic                   owner_d, owner_q;
  logic [C_WIDTH-1:0]     opa_d, opa_q;
  logic [C_WIDTH-1:0]     opb_d, opb_q;
  div_opcode_e            opcode_d, opcode_q;
  logic [C_LOG_WIDTH-1:0] shift_d, shift_q;
  logic                   zero_d, zero_q;
  logic                   sign_d, sign_q;
  logic [C_WIDTH-1:0]     res_d, res_q;
  logic                   err_d, err_q;
  logic [C_WDOG_W-1:0]    wdog_d, wdog_q;

  logic                   gnt_idx;
  div_opcode_e            gnt_opcode;
  logic                   gnt_sign, gnt_zero;
  logic [C_LOG_WIDTH-1:0] gnt_shift;
  logic [C_WDOG_W-1:0]    wdog_inc;
  logic                   wdog_exp;

  // A sole requester always wins; on a tie the pointer decides.
  assign gnt_idx    = (&ReqVld_SI) ? rr_q : ReqVld_SI[1];
  assign gnt_opcode = div_opcode_e'(ReqOpCode_SI[gnt_idx]);

  cv32e40p_div_prep #(
    .C_WIDTH     (C_WIDTH),
    .C_LOG_WIDTH (C_LOG_WIDTH)
  ) i_prep (
    .OpB_DI       (ReqOpB_DI[gnt_idx]),
    .OpCode_SI    (gnt_opcode),
    .OpBSign_SO   (gnt_sign),
    .OpBIsZero_SO (gnt_zero),
    .OpBShift_SO  (gnt_shift)
  );

  // Saturating watchdog increment and its abort condition.
  assign wdog_inc = (wdog_q == C_WDOG_W'(C_WDOG_CYC)) ? wdog_q : wdog_q + 1'b1;
  assign wdog_exp = (wdog_inc == C_WDOG_W'(C_WDOG_CYC));

  // Next-state, register updates and handshake outputs.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    opcode_d     = opcode_q;
    shift_d      = shift_q;
    zero_d       = zero_q;
    sign_d       = sign_q;
    res_d        = res_q;
    err_d        = err_q;
    wdog_d       = wdog_q;
    ReqRdy_SO    = 2'b00;
    RspVld_SO    = 2'b00;
    DivInVld_SO  = 1'b0;
    DivOutRdy_SO = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|ReqVld_SI) begin
          ReqRdy_SO[gnt_idx] = 1'b1;
          owner_d  = gnt_idx;
          opa_d    = ReqOpA_DI[gnt_idx];
          opb_d    = ReqOpB_DI[gnt_idx];
          opcode_d = gnt_opcode;
          shift_d  = gnt_shift;
          zero_d   = gnt_zero;
          sign_d   = gnt_sign;
          if (&ReqVld_SI) rr_d = ~gnt_idx;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // The pulse is issued even when flushing: the divider cannot be aborted.
        DivInVld_SO = 1'b1;
        wdog_d      = '0;
        state_d     = Flush_SI ? DRAIN : BUSY;
      end
      BUSY: begin
        DivOutRdy_SO = 1'b1;
        wdog_d       = wdog_inc;
        if (Flush_SI) begin
          // A result arriving together with flush is consumed and dropped.
          state_d = DivOutVld_SI ? IDLE : DRAIN;
        end else if (DivOutVld_SI) begin
          res_d   = DivRes_DI;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wdog_exp) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        RspVld_SO[owner_q] = 1'b1;
        if (Flush_SI || RspRdy_SI[owner_q]) state_d = IDLE;
      end
      DRAIN: begin
        DivOutRdy_SO = 1'b1;
        wdog_d       = wdog_inc;
        if (DivOutVld_SI || wdog_exp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      opcode_q <= DIV_UDIV;
      shift_q  <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      res_q    <= '0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opcode_q <= opcode_d;
      shift_q  <= shift_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      res_q    <= res_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  assign Busy_SO         = (state_q != IDLE);
  assign RspRes_DO       = res_q;
  assign RspErr_SO       = err_q;
  assign DivOpA_DO       = opa_q;
  assign DivOpB_DO       = opb_q;
  assign DivOpCode_SO    = opcode_q;
  assign DivOpBShift_DO  = shift_q;
  assign DivOpBIsZero_SO = zero_q;
  assign DivOpBSign_SO   = sign_q;

endmodule

// File: tb/tb_cv32e40p_div_arbiter.sv
// Self-checking bench for cv32e40p_div_arbiter with a behavioural divider model.
module tb_cv32e40p_div_arbiter;
  import cv32e40p_div_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_vld;
  logic [1:0]       req_rdy;
  logic [1:0][31:0] req_opa;
  logic [1:0][31:0] req_opb;
  logic [1:0][1:0]  req_opcode;
  logic [1:0]       rsp_vld;
  logic [1:0]       rsp_rdy;
  logic [31:0]      rsp_res;
  logic             rsp_err;
  logic             flush;
  logic             busy;
  logic [31:0]      div_opa, div_opb;
  logic [5:0]       div_shift;
  logic             div_zero, div_sign;
  logic [1:0]       div_opcode;
  logic             div_in_vld, div_out_rdy, div_out_vld;
  logic [31:0]      div_res;

  always #5 clk = ~clk;

  cv32e40p_div_arbiter dut (
    .Clk_CI          (clk),
    .Rst_RI          (rst),
    .ReqVld_SI       (req_vld),
    .ReqRdy_SO       (req_rdy),
    .ReqOpA_DI       (req_opa),
    .ReqOpB_DI       (req_opb),
    .ReqOpCode_SI    (req_opcode),
    .RspVld_SO       (rsp_vld),
    .RspRdy_SI       (rsp_rdy),
    .RspRes_DO       (rsp_res),
    .RspErr_SO       (rsp_err),
    .Flush_SI        (flush),
    .Busy_SO         (busy),
    .DivOpA_DO       (div_opa),
    .DivOpB_DO       (div_opb),
    .DivOpBShift_DO  (div_shift),
    .DivOpBIsZero_SO (div_zero),
    .DivOpBSign_SO   (div_sign),
    .DivOpCode_SO    (div_opcode),
    .DivInVld_SO     (div_in_vld),
    .DivOutRdy_SO    (div_out_rdy),
    .DivOutVld_SI    (div_out_vld),
    .DivRes_DI       (div_res)
  );

  // RISC-V divide/remainder semantics, including divide-by-zero and overflow.
  function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    div_ref = 32'h0;
    if (op == 2'd0) begin
      if (b == 0) div_ref = 32'hFFFF_FFFF; else div_ref = a / b;
    end else if (op == 2'd1) begin
      if (b == 0) div_ref = 32'hFFFF_FFFF; else if (ovf) div_ref = a; else div_ref = sa / sb;
    end else if (op == 2'd2) begin
      if (b == 0) div_ref = a; else div_ref = a % b;
    end else begin
      if (b == 0) div_ref = a; else if (ovf) div_ref = 32'h0; else div_ref = sa % sb;
    end
  endfunction

  // Divider model: fixed latency after InVld, result held until OutRdy.
  int          m_lat = 5;
  int          m_cnt = 0;
  logic        m_busy = 1'b0;
  logic        m_vld = 1'b0;
  logic [31:0] m_res = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_vld  <= 1'b0;
      m_cnt  <= 0;
      m_res  <= 32'h0;
    end else if (div_in_vld) begin
      m_busy <= 1'b1;
      m_vld  <= 1'b0;
      m_cnt  <= m_lat;
      m_res  <= div_ref(div_opa, div_opb, div_opcode);
    end else if (m_vld) begin
      if (div_out_rdy) begin
        m_vld  <= 1'b0;
        m_busy <= 1'b0;
      end
    end else if (m_busy) begin
      if (m_cnt == 0) m_vld <= 1'b1;
      else m_cnt <= m_cnt - 1;
    end
  end

  assign div_out_vld = m_vld;
  assign div_res     = m_res;

  typedef struct {
    logic        port;
    div_opcode_e op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  shift;
    logic        zero;
    logic        sign;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic        err;
  } exp_t;

  vec_t vecs[9];
  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive_req(input logic p, input div_opcode_e op, input logic [31:0] a,
                           input logic [31:0] b);
    req_opa[p]    = a;
    req_opb[p]    = b;
    req_opcode[p] = op;
    req_vld[p]    = 1'b1;
  endtask

  task automatic push_exp(input logic p, input logic [31:0] res, input logic err);
    exp_t e;
    e.port = p;
    e.res  = res;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  // Waits for the grant of port p, then returns at the negedge of the ISSUE cycle.
  task automatic wait_grant(input logic p);
    int i = 0;
    #1;
    while (!req_rdy[p] && i < 100) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("grant_seen", 32'(req_rdy[p]), 32'd1);
    @(negedge clk);
    req_vld[p] = 1'b0;
    check("invld_lat1", 32'(div_in_vld), 32'd1);
  endtask

  // Waits for a response, compares it with the scoreboard head, then retires it.
  task automatic wait_resp();
    exp_t e;
    int   i = 0;
    while (rsp_vld == 2'b00 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check("rsp_vld", 32'(rsp_vld), 32'(2'b01 << e.port));
    check("rsp_res", rsp_res, e.res);
    check("rsp_err", 32'(rsp_err), 32'(e.err));
    rsp_rdy = 2'b01 << ~e.port;
    @(negedge clk);
    check("rsp_nonowner_rdy", 32'(rsp_vld), 32'(2'b01 << e.port));
    rsp_rdy = 2'b01 << e.port;
    @(negedge clk);
    rsp_rdy = 2'b00;
    check("rsp_to_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int   cnt;
    logic saw_vld, saw_rsp;

    vecs[0] = '{1'b0, DIV_UDIV, 32'd100,       32'd7,         6'd29, 1'b0, 1'b0, 32'd14};
    vecs[1] = '{1'b1, DIV_REM,  32'hFFFF_FF9C, 32'd7,         6'd29, 1'b0, 1'b0, 32'hFFFF_FFFE};
    vecs[2] = '{1'b1, DIV_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 6'd29, 1'b0, 1'b1, 32'd14};
    vecs[3] = '{1'b0, DIV_UDIV, 32'd5,         32'd0,         6'd32, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[4] = '{1'b0, DIV_UREM, 32'd5,         32'd0,         6'd32, 1'b1, 1'b0, 32'd5};
    vecs[5] = '{1'b1, DIV_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 6'd31, 1'b0, 1'b1, 32'h8000_0000};
    vecs[6] = '{1'b0, DIV_REM,  32'd7,         32'h8000_0000, 6'd0,  1'b0, 1'b1, 32'd7};
    vecs[7] = '{1'b1, DIV_UDIV, 32'hFFFF_FFFF, 32'd1,         6'd31, 1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[8] = '{1'b0, DIV_UDIV, 32'hFFFF_FFFF, 32'h8000_0000, 6'd0,  1'b0, 1'b0, 32'd1};

    rst        = 1'b1;
    req_vld    = 2'b00;
    req_opa    = '0;
    req_opb    = '0;
    req_opcode = '0;
    rsp_rdy    = 2'b00;
    flush      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_reqrdy",  32'(req_rdy),     32'd0);
    check("rst_rspvld",  32'(rsp_vld),     32'd0);
    check("rst_rsperr",  32'(rsp_err),     32'd0);
    check("rst_invld",   32'(div_in_vld),  32'd0);
    check("rst_outrdy",  32'(div_out_rdy), 32'd0);
    check("rst_rspres",  rsp_res,          32'd0);
    check("rst_shift",   32'(div_shift),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single requests
    for (int k = 0; k < 9; k++) begin
      drive_req(vecs[k].port, vecs[k].op, vecs[k].a, vecs[k].b);
      push_exp(vecs[k].port, vecs[k].res, 1'b0);
      wait_grant(vecs[k].port);
      check("div_opb",    div_opb,           vecs[k].b);
      check("div_opcode", 32'(div_opcode),   32'(vecs[k].op));
      check("div_shift",  32'(div_shift),    32'(vecs[k].shift));
      check("div_zero",   32'(div_zero),     32'(vecs[k].zero));
      check("div_sign",   32'(div_sign),     32'(vecs[k].sign));
      @(negedge clk);
      check("invld_one_cycle", 32'(div_in_vld), 32'd0);
      wait_resp();
    end

    // Flush during BUSY: drain silently until the divider delivers
    m_lat = 20;
    drive_req(1'b0, DIV_UDIV, 32'd40, 32'd4);
    wait_grant(1'b0);
    @(negedge clk);
    check("flush_busy_outrdy", 32'(div_out_rdy), 32'd1);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_drain_busy", 32'(busy), 32'd1);
    saw_vld = 1'b0;
    saw_rsp = 1'b0;
    for (int i = 0; i < 100 && busy; i++) begin
      saw_vld = saw_vld | div_out_vld;
      saw_rsp = saw_rsp | (|rsp_vld);
      @(negedge clk);
    end
    check("flush_idle",         32'(busy),    32'd0);
    check("flush_waits_outvld", 32'(saw_vld), 32'd1);
    check("flush_no_rsp",       32'(saw_rsp), 32'd0);
    m_lat = 5;
    drive_req(1'b1, DIV_UDIV, 32'd40, 32'd4);
    push_exp(1'b1, 32'd10, 1'b0);
    wait_grant(1'b1);
    wait_resp();

    // Flush coinciding with OutVld in BUSY: result dropped, straight to IDLE
    m_lat = 3;
    drive_req(1'b0, DIV_UREM, 32'd40, 32'd6);
    wait_grant(1'b0);
    for (int i = 0; i < 100 && !div_out_vld; i++) @(negedge clk);
    check("flushvld_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flushvld_idle",   32'(busy),        32'd0);
    check("flushvld_no_rsp", 32'(rsp_vld),     32'd0);
    @(negedge clk);
    check("flushvld_consumed", 32'(div_out_vld), 32'd0);
    check("flushvld_no_rsp2",  32'(rsp_vld),     32'd0);
    m_lat = 5;

    // Round robin: tie with pointer 0, then tie with pointer 1
    drive_req(1'b0, DIV_UDIV, 32'd20, 32'd3);
    drive_req(1'b1, DIV_UREM, 32'd20, 32'd3);
    #1;
    check("rr_first", 32'(req_rdy), 32'(2'b01));
    push_exp(1'b0, 32'd6, 1'b0);
    wait_grant(1'b0);
    check("rr_busy_no_rdy", 32'(req_rdy), 32'd0);
    wait_resp();
    #1;
    check("rr_second", 32'(req_rdy), 32'(2'b10));
    push_exp(1'b1, 32'd2, 1'b0);
    wait_grant(1'b1);
    wait_resp();
    drive_req(1'b0, DIV_UDIV, 32'd30, 32'd4);
    drive_req(1'b1, DIV_DIV,  32'hFFFF_FFE2, 32'd4);
    #1;
    check("rr_third", 32'(req_rdy), 32'(2'b10));
    push_exp(1'b1, 32'hFFFF_FFF9, 1'b0);
    wait_grant(1'b1);
    wait_resp();
    #1;
    check("rr_fourth", 32'(req_rdy), 32'(2'b01));
    push_exp(1'b0, 32'd7, 1'b0);
    wait_grant(1'b0);
    wait_resp();

    // Watchdog: divider stalls 60 cycles, abort after 48 BUSY cycles
    m_lat = 60;
    drive_req(1'b1, DIV_UDIV, 32'd50, 32'd5);
    push_exp(1'b1, 32'd0, 1'b1);
    wait_grant(1'b1);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_vld != 2'b00) break;
      if (div_out_rdy) cnt++;
    end
    check("wdog_busy_cycles", 32'(cnt), 32'd48);
    wait_resp();

    // Reset while BUSY: everything back to reset values on the next edge
    m_lat = 30;
    drive_req(1'b0, DIV_UDIV, 32'd9, 32'd2);
    wait_grant(1'b0);
    repeat (3) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",   32'(busy),        32'd0);
    check("midrst_outrdy", 32'(div_out_rdy), 32'd0);
    check("midrst_invld",  32'(div_in_vld),  32'd0);
    check("midrst_rspvld", 32'(rsp_vld),     32'd0);
    check("midrst_rsperr", 32'(rsp_err),     32'd0);
    check("midrst_opa",    div_opa,          32'd0);
    check("midrst_opb",    div_opb,          32'd0);
    check("midrst_shift",  32'(div_shift),   32'd0);
    rst = 1'b0;
    m_lat = 5;
    @(negedge clk);
    drive_req(1'b1, DIV_UDIV, 32'd9, 32'd2);
    push_exp(1'b1, 32'd4, 1'b0);
    wait_grant(1'b1);
    wait_resp();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
